// File: rtl/cpu_sequencer_pkg.sv
// Shared sequencer definitions: FSM state encoding used by cpu_sequencer.
package cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_FETCH = 2'd0,
    SEQ_EXEC  = 2'd1,
    SEQ_HALT  = 2'd2,
    SEQ_FAULT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_return_stack.sv
// return_stack: parametrised LIFO of return addresses with occupancy count.
module return_stack
  import cpu_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic [W-1:0]    top_data,
  output logic            full,
  output logic            empty,
  output logic [SP_W-1:0] count
);

  logic [SP_W-1:0] count_r;
  // Power-of-two storage lets the occupancy count index it directly.
  logic [W-1:0]    mem_r [0:(1 << SP_W) - 1];

  assign full     = (count_r == SP_W'(DEPTH));
  assign empty    = (count_r == {SP_W{1'b0}});
  assign count    = count_r;
  assign top_data = mem_r[count_r - SP_W'(1)];

  // Occupancy counter; refuses to move past empty or full.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_r <= {SP_W{1'b0}};
    end else if (push && !full) begin
      count_r <= count_r + SP_W'(1);
    end else if (pop && !empty) begin
      count_r <= count_r - SP_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Storage write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[count_r] <= push_data;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: IP owner, handshaked ROM fetch, branch/call/ret/halt sequencing.
// Optional single-step from HALT via macro CPU_SEQ_SINGLE_STEP_EN (adds port step).
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int IP_W        = 8,
  parameter int INSTR_W     = 32,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_IP    = 0
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               enable,
  output logic [IP_W-1:0]                    imem_addr,
  output logic                               imem_req,
  input  logic                               imem_valid,
  input  logic [INSTR_W-1:0]                 imem_data,
  output logic [INSTR_W-1:0]                 instr,
  output logic                               instr_valid,
  input  logic                               br_taken,
  input  logic                               is_call,
  input  logic                               is_ret,
  input  logic                               is_halt,
  input  logic [IP_W-1:0]                    target,
  input  logic                               resume,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                               step,
`endif
  output logic [IP_W-1:0]                    ip,
  output logic                               halted,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  seq_state_e         state_r;
  logic [IP_W-1:0]    ip_r;
  logic [INSTR_W-1:0] instr_r;
  logic               instr_valid_r;
  logic               imem_req_r;
  logic               halted_r;
  logic               stack_err_r;
  logic               hold_halt_r, hold_ret_r, hold_call_r, hold_br_r;
  logic [IP_W-1:0]    hold_target_r;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic               step_mode_r;
`endif

  logic               eff_halt_s, eff_ret_s, eff_call_s, eff_br_s;
  logic [IP_W-1:0]    eff_target_s;
  logic               push_s, pop_s, full_s, empty_s;
  logic [IP_W-1:0]    top_s;
  logic [IP_W-1:0]    ip_inc_s;

  // Controls are live on the first EXEC cycle and come from the hold registers afterwards.
  assign eff_halt_s   = instr_valid_r ? is_halt  : hold_halt_r;
  assign eff_ret_s    = instr_valid_r ? is_ret   : hold_ret_r;
  assign eff_call_s   = instr_valid_r ? is_call  : hold_call_r;
  assign eff_br_s     = instr_valid_r ? br_taken : hold_br_r;
  assign eff_target_s = instr_valid_r ? target   : hold_target_r;
  assign ip_inc_s     = ip_r + IP_W'(1);

  // Stack side-effects only for the winning control of an advancing instruction.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if ((state_r == SEQ_EXEC) && enable) begin
      if (eff_halt_s) begin
        push_s = 1'b0;
      end else if (eff_ret_s) begin
        pop_s = !empty_s;
      end else if (eff_call_s) begin
        push_s = !full_s;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (IP_W)
  ) u_stack (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (ip_inc_s),
    .top_data  (top_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (sp)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= SEQ_FETCH;
      ip_r          <= IP_W'(RESET_IP);
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      imem_req_r    <= 1'b1;
      halted_r      <= 1'b0;
      stack_err_r   <= 1'b0;
      hold_halt_r   <= 1'b0;
      hold_ret_r    <= 1'b0;
      hold_call_r   <= 1'b0;
      hold_br_r     <= 1'b0;
      hold_target_r <= {IP_W{1'b0}};
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step_mode_r   <= 1'b0;
`endif
    end else begin
      instr_valid_r <= 1'b0;
      case (state_r)
        SEQ_FETCH: begin
          if (imem_valid) begin
            instr_r       <= imem_data;
            instr_valid_r <= 1'b1;
            imem_req_r    <= 1'b0;
            state_r       <= SEQ_EXEC;
          end
        end
        SEQ_EXEC: begin
          if (instr_valid_r) begin
            hold_halt_r   <= is_halt;
            hold_ret_r    <= is_ret;
            hold_call_r   <= is_call;
            hold_br_r     <= br_taken;
            hold_target_r <= target;
          end
          if (enable) begin
            state_r    <= SEQ_FETCH;
            imem_req_r <= 1'b1;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            step_mode_r <= 1'b0;
`endif
            if (eff_halt_s) begin
              ip_r       <= ip_inc_s;
              state_r    <= SEQ_HALT;
              imem_req_r <= 1'b0;
              halted_r   <= 1'b1;
            end else if (eff_ret_s) begin
              if (empty_s) begin
                state_r     <= SEQ_FAULT;
                imem_req_r  <= 1'b0;
                stack_err_r <= 1'b1;
              end else begin
                ip_r <= top_s;
              end
            end else if (eff_call_s) begin
              if (full_s) begin
                state_r     <= SEQ_FAULT;
                imem_req_r  <= 1'b0;
                stack_err_r <= 1'b1;
              end else begin
                ip_r <= eff_target_s;
              end
            end else if (eff_br_s) begin
              ip_r <= eff_target_s;
            end else begin
              ip_r <= ip_inc_s;
`ifdef CPU_SEQ_SINGLE_STEP_EN
              if (step_mode_r) begin
                state_r    <= SEQ_HALT;
                imem_req_r <= 1'b0;
                halted_r   <= 1'b1;
              end
`endif
            end
          end
        end
        SEQ_HALT: begin
          if (resume) begin
            state_r    <= SEQ_FETCH;
            imem_req_r <= 1'b1;
            halted_r   <= 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
          end else if (step) begin
            state_r     <= SEQ_FETCH;
            imem_req_r  <= 1'b1;
            halted_r    <= 1'b0;
            step_mode_r <= 1'b1;
`endif
          end
        end
        SEQ_FAULT: begin
          stack_err_r <= 1'b1;
          imem_req_r  <= 1'b0;
        end
        default: begin
          state_r     <= SEQ_FAULT;
          imem_req_r  <= 1'b0;
          stack_err_r <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr   = ip_r;
  assign imem_req    = imem_req_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign ip          = ip_r;
  assign halted      = halted_r;
  assign stack_err   = stack_err_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle comparison against a transaction-level model.
module tb_cpu_sequencer;

  localparam int          DEPTH = 4;
  localparam logic [7:0]  RST   = 8'h20;
  localparam int          M_FETCH = 0, M_EXEC = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        resetn, enable, imem_valid, br_taken, is_call, is_ret, is_halt, resume;
  logic [31:0] imem_data;
  logic [7:0]  target;
  logic [7:0]  imem_addr, ip;
  logic        imem_req, instr_valid, halted, stack_err;
  logic [31:0] instr;
  logic [2:0]  sp;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model state: what the sequencer must be doing, kept as mode + queue.
  int         m_mode;
  logic [7:0] m_ip;
  logic [31:0] m_instr;
  bit         m_fresh;
  bit [7:0]   m_stack[$];
  bit         p_h, p_r, p_c, p_b;
  logic [7:0] p_t;

  cpu_sequencer #(.IP_W(8), .INSTR_W(32), .STACK_DEPTH(DEPTH), .RESET_IP(32'h20)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_valid(imem_valid), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid),
    .br_taken(br_taken), .is_call(is_call), .is_ret(is_ret), .is_halt(is_halt),
    .target(target), .resume(resume),
    .ip(ip), .halted(halted), .stack_err(stack_err), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      m_ip = RST; m_mode = M_FETCH; m_stack.delete(); m_instr = 32'h0; m_fresh = 1'b0;
    end else begin
      case (m_mode)
        M_FETCH: if (imem_valid) begin m_instr = imem_data; m_mode = M_EXEC; m_fresh = 1'b1; end
        M_EXEC: begin
          if (m_fresh) begin
            p_h = is_halt; p_r = is_ret; p_c = is_call; p_b = br_taken; p_t = target; m_fresh = 1'b0;
          end
          if (enable) begin
            m_mode = M_FETCH;
            if (p_h) begin m_ip = m_ip + 8'd1; m_mode = M_HALT; end
            else if (p_r) begin
              if (m_stack.size() == 0) m_mode = M_FAULT;
              else m_ip = m_stack.pop_back();
            end else if (p_c) begin
              if (m_stack.size() == DEPTH) m_mode = M_FAULT;
              else begin m_stack.push_back(m_ip + 8'd1); m_ip = p_t; end
            end else if (p_b) m_ip = p_t;
            else m_ip = m_ip + 8'd1;
          end
        end
        M_HALT: if (resume) m_mode = M_FETCH;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ip",          32'(ip),          32'(m_ip));
      chk("imem_addr",   32'(imem_addr),   32'(m_ip));
      chk("imem_req",    32'(imem_req),    32'(m_mode == M_FETCH));
      chk("instr_valid", 32'(instr_valid), 32'(m_fresh));
      chk("instr",       instr,            m_instr);
      chk("halted",      32'(halted),      32'(m_mode == M_HALT));
      chk("stack_err",   32'(stack_err),   32'(m_mode == M_FAULT));
      chk("sp",          32'(sp),          32'(m_stack.size()));
    end
  end

  task automatic clear_ctl();
    is_halt = 1'b0; is_ret = 1'b0; is_call = 1'b0; br_taken = 1'b0; target = 8'hEE;
  endtask

  // One instruction: ROM waits, capture, optional enable stall, advance.
  task automatic exec_instr(input bit h, input bit r, input bit c, input bit b,
                            input logic [7:0] tgt, input int waits, input int stall);
    imem_valid = 1'b0; imem_data = 32'hDEADBEEF;
    for (int i = 0; i < waits; i++) tick();
    imem_valid = 1'b1; imem_data = {24'hC0DE00, m_ip};
    tick();
    imem_data = 32'hDEADBEEF;
    is_halt = h; is_ret = r; is_call = c; br_taken = b; target = tgt;
    if (stall > 0) begin
      enable = 1'b0;
      tick();
      clear_ctl();
      for (int i = 1; i < stall; i++) tick();
      chk("stall_no_valid", 32'(instr_valid), 32'h0);
      enable = 1'b1;
    end
    tick();
    clear_ctl();
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; imem_valid = 1'b0; imem_data = 32'h0;
    resume = 1'b0; clear_ctl();
    tick(); tick();
    resetn = 1'b1; chk_on = 1'b1;
    chk("rst_ip", 32'(ip), 32'h20);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h1);
    chk("rst_instr", instr, 32'h0);

    // Straight-line run
    for (int k = 0; k < 4; k++) exec_instr(0, 0, 0, 0, 8'h00, 0, 0);
    chk("seq_ip", 32'(ip), 32'h24);

    // Branch to 5, then slow ROM at 5, resume outside HALT ignored
    exec_instr(0, 0, 0, 1, 8'h05, 0, 0);
    resume = 1'b1;
    exec_instr(0, 0, 0, 0, 8'h00, 3, 0);
    resume = 1'b0;
    chk("slow_ip", 32'(ip), 32'h06);
    chk("slow_instr", instr, 32'hC0DE0005);

    // Enable stall: controls from the first EXEC cycle are honoured
    exec_instr(0, 0, 0, 1, 8'h30, 0, 3);
    chk("stall_ip", 32'(ip), 32'h30);

    // Call / return
    exec_instr(0, 0, 0, 1, 8'h10, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h40, 0, 0);
    chk("call_ip", 32'(ip), 32'h40);
    chk("call_sp", 32'(sp), 32'h1);
    exec_instr(0, 1, 0, 0, 8'h00, 0, 0);
    chk("ret_ip", 32'(ip), 32'h11);
    chk("ret_sp", 32'(sp), 32'h0);

    // Call and branch together: call wins
    exec_instr(0, 0, 1, 1, 8'h50, 0, 0);
    chk("callbr_sp", 32'(sp), 32'h1);
    exec_instr(0, 1, 1, 1, 8'h77, 0, 0);
    chk("retcall_ip", 32'(ip), 32'h12);

    // Halt at top address wraps; resume
    exec_instr(0, 0, 0, 1, 8'hFF, 0, 0);
    exec_instr(1, 1, 1, 1, 8'h33, 0, 0);
    chk("halt_ip", 32'(ip), 32'h00);
    chk("halt_flag", 32'(halted), 32'h1);
    imem_valid = 1'b1;
    tick(); tick();
    resume = 1'b1; tick(); resume = 1'b0;
    exec_instr(0, 0, 0, 0, 8'h00, 0, 0);
    chk("resume_ip", 32'(ip), 32'h01);

    // Call at top address pushes 0
    exec_instr(0, 0, 0, 1, 8'hFF, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h60, 0, 0);
    exec_instr(0, 1, 0, 0, 8'h00, 0, 0);
    chk("wrap_ret_ip", 32'(ip), 32'h00);

    // Overflow: fifth nested call faults
    exec_instr(0, 0, 1, 0, 8'h70, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h71, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h72, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h73, 0, 0);
    exec_instr(0, 0, 1, 0, 8'h90, 0, 0);
    chk("ovf_err", 32'(stack_err), 32'h1);
    chk("ovf_ip", 32'(ip), 32'h73);
    chk("ovf_sp", 32'(sp), 32'h4);
    resume = 1'b1; tick(); tick(); resume = 1'b0;

    // Underflow after reset
    resetn = 1'b0; tick(); resetn = 1'b1;
    exec_instr(0, 1, 0, 0, 8'h00, 0, 0);
    chk("udf_err", 32'(stack_err), 32'h1);
    chk("udf_ip", 32'(ip), 32'h20);

    // Reset mid-FETCH
    resetn = 1'b0; tick(); resetn = 1'b1;
    exec_instr(0, 0, 1, 0, 8'h44, 0, 0);
    imem_valid = 1'b0; tick(); tick();
    resetn = 1'b0; imem_valid = 1'b1; tick(); resetn = 1'b1;
    chk("midrst_ip", 32'(ip), 32'h20);
    chk("midrst_sp", 32'(sp), 32'h0);
    chk("midrst_err", 32'(stack_err), 32'h0);
    chk("midrst_req", 32'(imem_req), 32'h1);
    exec_instr(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
